raster_sequencer: RTL and testbench
===================================

# raster_sequencer

Converts decoded rasterizer commands into a per-pixel framebuffer write stream for the 8x8 1-bit framebuffer. Sits between the command decoder (command, coordinates, one-cycle `command_valid` pulse) and the framebuffer write port. Sequences PIXEL, CLEAR, LINE (Bresenham) and FILL_RECT at one pixel write per clock, and reports busy/done/drop status.

## Interface

- `DRAW_VALUE`, 1'b1, pixel value written by PIXEL, LINE and RECT
- `CLEAR_VALUE`, 1'b0, pixel value written by CLEAR

- `clk`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `command_valid`  in  1  one-cycle pulse: `command` and coordinate inputs are valid
- `command`  in  2  00 NOOP, 01 PIXEL/CLEAR, 10 LINE, 11 FILL_RECT
- `x1`, `y1`, `x2`, `y2`  in  3 each  coordinates
- `rect_width`, `rect_height`  in  3 each  rectangle size
- `fb_we`  out  1  framebuffer write strobe
- `fb_x`, `fb_y`  out  3 each  write address
- `fb_data`  out  1  write data
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse when a command completes
- `cmd_drop`  out  1  one-cycle pulse when an accepted pulse is discarded

## Operation

- Decode: 01 with x1==7 is CLEAR, otherwise PIXEL at (x1,y1); 10 is LINE (x1,y1)->(x2,y2); 11 is RECT, origin (x1,y1), size rect_width x rect_height.
- States: IDLE, PIXEL, CLEAR, LINE, RECT. Inputs are captured into internal registers at acceptance. Later input changes have no effect.
- IDLE + `command_valid`: go to the command's state. NOOP stays in IDLE and pulses `done` next cycle with no writes.
- PIXEL: one write of DRAW_VALUE.
- CLEAR: 64 writes of CLEAR_VALUE, raster order (x inner, y outer), from (0,0) to (7,7).
- LINE: Bresenham algorithm.
  - Setup: dx=|x2-x1|, dy=-|y2-y1|, err=dx+dy (5-bit signed), sx/sy=±1.
  - Each cycle write (x,y). If (x,y)==(x2,y2), finish.
  - Otherwise e2=2*err (6-bit signed). If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy.
  - Write count is max(|dx|,|dy|)+1. A zero-length line gives 1 write.
- RECT: x runs from x1 to x1+rect_width-1 (inner loop), y from y1 to y1+rect_height-1 (outer loop).
  - End is computed in 4 bits and clipped to 7.
  - rect_width==0 or rect_height==0: no writes; `done` pulses next cycle.
- Every pixel is written exactly once; there is no read-modify-write.
- `command_valid` while `busy`: behaviour is set by the Configuration section.

## Timing

- Reset value of every output: fb_we=0, fb_x=0, fb_y=0, fb_data=0, busy=0, done=0, cmd_drop=0. Reset also sets state=IDLE and clears the buffer.
- Reset asserted mid-command aborts the command immediately. No further writes occur and no `done` is issued.
- All outputs are registered.
- Pulse accepted in cycle N: first `fb_we` in cycle N+1. `busy` is high from N+1 through the last write cycle.
- `done` is high for one cycle immediately after the last write. `busy` is 0 in that cycle, and a new `command_valid` in that cycle is accepted.
- Back-to-back throughput: a PIXEL command occupies 2 cycles of the accept-to-accept interval.
- `fb_we` is continuous (one write per cycle) for the duration of a command. `fb_x`, `fb_y` and `fb_data` hold their last values when `fb_we`=0.

## Configuration

- `RASTER_SEQ_CMD_BUF_EN` defined: adds a one-entry command buffer.
  - A pulse arriving while busy is stored if the buffer is empty. If the buffer is full, the pulse is discarded and `cmd_drop` pulses the next cycle.
  - In IDLE with the buffer valid, the buffered command starts and the buffer frees. A simultaneous `command_valid` in that cycle is written into the freed buffer.
- Not defined: any pulse arriving while busy is discarded, and `cmd_drop` pulses the next cycle.

## Test plan

- Reset, then PIXEL (3,5) pulse at N -> fb_we=1, (3,5), data 1 at N+1 only; done at N+2; busy only at N+1.
- CLEAR (cmd 01, x1=7) -> 64 consecutive writes, data 0, order (0,0),(1,0)..(7,7); done in the cycle after (7,7).
- LINE (0,0)->(7,3) -> writes (0,0),(1,0),(2,1),(3,1),(4,2),(5,2),(6,3),(7,3); also run the reverse (7,3)->(0,0) -> same 8 pixels.
- RECT (2,3) w=3 h=2 -> (2,3),(3,3),(4,3),(2,4),(3,4),(4,4). RECT (6,6) w=4 h=4 -> (6,6),(7,6),(6,7),(7,7). RECT w=0 -> no writes, done at N+1.
- Two pulses during a CLEAR:
  - Buffer enabled: first is buffered, second gives `cmd_drop`; the buffered command starts the cycle after CLEAR's `done`.
  - Buffer disabled: both give `cmd_drop`.
- Assert rst_n low at the 10th CLEAR write -> all outputs 0 asynchronously; no `done`; a new PIXEL after reset executes normally.

Source files
------------

// File: rtl/raster_sequencer_if.sv
// rtl/raster_sequencer_if.sv - command input and framebuffer write bundle for raster_sequencer
interface raster_sequencer_if;
    logic       command_valid;
    logic [1:0] command;
    logic [2:0] x1;
    logic [2:0] y1;
    logic [2:0] x2;
    logic [2:0] y2;
    logic [2:0] rect_width;
    logic [2:0] rect_height;
    logic       fb_we;
    logic [2:0] fb_x;
    logic [2:0] fb_y;
    logic       fb_data;
    logic       busy;
    logic       done;
    logic       cmd_drop;

    modport master (
        output command_valid, command, x1, y1, x2, y2, rect_width, rect_height,
        input  fb_we, fb_x, fb_y, fb_data, busy, done, cmd_drop
    );

    modport slave (
        input  command_valid, command, x1, y1, x2, y2, rect_width, rect_height,
        output fb_we, fb_x, fb_y, fb_data, busy, done, cmd_drop
    );
endinterface

// File: rtl/raster_sequencer.sv
// rtl/raster_sequencer.sv - sequences PIXEL/CLEAR/LINE/FILL_RECT into one framebuffer write per clock
// Optional one-entry command buffer: define RASTER_SEQ_CMD_BUF_EN
module raster_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    raster_sequencer_if.slave bus
);
    localparam logic DRAW_VALUE  = 1'b1;
    localparam logic CLEAR_VALUE = 1'b0;

    typedef enum logic [2:0] {S_IDLE, S_PIXEL, S_CLEAR, S_LINE, S_RECT} state_t;

    typedef struct packed {
        logic [1:0] cmd;
        logic [2:0] x1;
        logic [2:0] y1;
        logic [2:0] x2;
        logic [2:0] y2;
        logic [2:0] w;
        logic [2:0] h;
    } cmd_t;

    state_t            state_q, state_d;
    logic [2:0]        x_q, x_d, y_q, y_d;
    logic              fb_we_q, fb_we_d, fb_data_q, fb_data_d;
    logic              busy_q, busy_d, done_q, done_d, drop_q, drop_d;
    logic [2:0]        xs_q, xs_d, xe_q, xe_d, ye_q, ye_d;
    logic signed [4:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d, err_step;
    logic signed [5:0] e2, dx_ext, dy_ext;
    logic              sx_q, sx_d, sy_q, sy_d;

    cmd_t       in_cmd, start_cmd;
    logic       start;
    logic [2:0] adx, ady;
    logic [3:0] rxe, rye;

    assign in_cmd = {bus.command, bus.x1, bus.y1, bus.x2, bus.y2, bus.rect_width, bus.rect_height};

`ifdef RASTER_SEQ_CMD_BUF_EN
    cmd_t buf_q, buf_d;
    logic buf_valid_q, buf_valid_d;

    // A freed buffer slot can be refilled in the same cycle it is drained.
    always_comb begin
        start_cmd   = in_cmd;
        start       = 1'b0;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        drop_d      = 1'b0;
        if (state_q == S_IDLE) begin
            if (buf_valid_q) begin
                start       = 1'b1;
                start_cmd   = buf_q;
                buf_valid_d = bus.command_valid;
                buf_d       = in_cmd;
            end else begin
                start = bus.command_valid;
            end
        end else if (bus.command_valid) begin
            if (buf_valid_q) begin
                drop_d = 1'b1;
            end else begin
                buf_valid_d = 1'b1;
                buf_d       = in_cmd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end
`else
    always_comb begin
        start_cmd = in_cmd;
        start     = (state_q == S_IDLE) && bus.command_valid;
        drop_d    = (state_q != S_IDLE) && bus.command_valid;
    end
`endif

    assign adx    = (start_cmd.x2 >= start_cmd.x1) ? start_cmd.x2 - start_cmd.x1 : start_cmd.x1 - start_cmd.x2;
    assign ady    = (start_cmd.y2 >= start_cmd.y1) ? start_cmd.y2 - start_cmd.y1 : start_cmd.y1 - start_cmd.y2;
    assign rxe    = {1'b0, start_cmd.x1} + {1'b0, start_cmd.w} - 4'd1;
    assign rye    = {1'b0, start_cmd.y1} + {1'b0, start_cmd.h} - 4'd1;
    assign dx_ext = {dx_q[4], dx_q};
    assign dy_ext = {dy_q[4], dy_q};

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        fb_we_d   = 1'b0;
        fb_data_d = fb_data_q;
        done_d    = 1'b0;
        xs_d      = xs_q;
        xe_d      = xe_q;
        ye_d      = ye_q;
        err_d     = err_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        e2        = {err_q, 1'b0};
        err_step  = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (start_cmd.cmd)
                        2'b00: done_d = 1'b1;
                        2'b01: begin
                            fb_we_d = 1'b1;
                            if (start_cmd.x1 == 3'd7) begin
                                state_d   = S_CLEAR;
                                x_d       = 3'd0;
                                y_d       = 3'd0;
                                xs_d      = 3'd0;
                                xe_d      = 3'd7;
                                ye_d      = 3'd7;
                                fb_data_d = CLEAR_VALUE;
                            end else begin
                                state_d   = S_PIXEL;
                                x_d       = start_cmd.x1;
                                y_d       = start_cmd.y1;
                                fb_data_d = DRAW_VALUE;
                            end
                        end
                        2'b10: begin
                            state_d   = S_LINE;
                            fb_we_d   = 1'b1;
                            fb_data_d = DRAW_VALUE;
                            x_d       = start_cmd.x1;
                            y_d       = start_cmd.y1;
                            xe_d      = start_cmd.x2;
                            ye_d      = start_cmd.y2;
                            dx_d      = $signed({2'b00, adx});
                            dy_d      = -$signed({2'b00, ady});
                            err_d     = $signed({2'b00, adx}) - $signed({2'b00, ady});
                            sx_d      = start_cmd.x2 < start_cmd.x1;
                            sy_d      = start_cmd.y2 < start_cmd.y1;
                        end
                        default: begin
                            if (start_cmd.w == 3'd0 || start_cmd.h == 3'd0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d   = S_RECT;
                                fb_we_d   = 1'b1;
                                fb_data_d = DRAW_VALUE;
                                x_d       = start_cmd.x1;
                                y_d       = start_cmd.y1;
                                xs_d      = start_cmd.x1;
                                xe_d      = rxe[3] ? 3'd7 : rxe[2:0];
                                ye_d      = rye[3] ? 3'd7 : rye[2:0];
                            end
                        end
                    endcase
                end
            end
            S_PIXEL: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            // CLEAR is a full-screen rectangle: both share the raster walk.
            S_CLEAR, S_RECT: begin
                if (x_q == xe_q) begin
                    if (y_q == ye_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        fb_we_d = 1'b1;
                        x_d     = xs_q;
                        y_d     = y_q + 3'd1;
                    end
                end else begin
                    fb_we_d = 1'b1;
                    x_d     = x_q + 3'd1;
                end
            end
            S_LINE: begin
                if (x_q == xe_q && y_q == ye_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    fb_we_d = 1'b1;
                    if (e2 >= dy_ext) begin
                        err_step = err_step + dy_q;
                        x_d      = sx_q ? x_q - 3'd1 : x_q + 3'd1;
                    end
                    if (e2 <= dx_ext) begin
                        err_step = err_step + dx_q;
                        y_d      = sy_q ? y_q - 3'd1 : y_q + 3'd1;
                    end
                    err_d = err_step;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= 3'd0;
            y_q       <= 3'd0;
            fb_we_q   <= 1'b0;
            fb_data_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            xs_q      <= 3'd0;
            xe_q      <= 3'd0;
            ye_q      <= 3'd0;
            err_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fb_we_q   <= fb_we_d;
            fb_data_q <= fb_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
            xs_q      <= xs_d;
            xe_q      <= xe_d;
            ye_q      <= ye_d;
            err_q     <= err_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
        end
    end

    assign bus.fb_we    = fb_we_q;
    assign bus.fb_x     = x_q;
    assign bus.fb_y     = y_q;
    assign bus.fb_data  = fb_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cmd_drop = drop_q;
endmodule

// File: tb/tb_raster_sequencer.sv
// tb/tb_raster_sequencer.sv - self-checking bench for raster_sequencer against a pixel-list model
module tb_raster_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    raster_sequencer_if bus ();
    raster_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic       d;
    } pix_t;

    pix_t exp_q[$];
    pix_t last_pix;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic we, input logic [2:0] x, input logic [2:0] y,
                             input logic d, input logic busy, input logic done, input logic drop);
        check({tag, ".fb_we"}, bus.fb_we, we);
        check({tag, ".fb_x"}, bus.fb_x, x);
        check({tag, ".fb_y"}, bus.fb_y, y);
        check({tag, ".fb_data"}, bus.fb_data, d);
        check({tag, ".busy"}, bus.busy, busy);
        check({tag, ".done"}, bus.done, done);
        check({tag, ".cmd_drop"}, bus.cmd_drop, drop);
    endtask

    function automatic void push(input int px, input int py, input logic pd);
        exp_q.push_back(pix_t'{x: 3'(px), y: 3'(py), d: pd});
    endfunction

    // Expected write list for one command, straight from the drawing rules.
    function automatic void build_expected(input int c, input int a, input int b, input int d,
                                           input int e, input int w, input int h);
        int x, y, dx, dy, sx, sy, err, e2, xe, ye;
        exp_q.delete();
        case (c)
            1: begin
                if (a == 7) begin
                    for (int yy = 0; yy < 8; yy++)
                        for (int xx = 0; xx < 8; xx++) push(xx, yy, 1'b0);
                end else begin
                    push(a, b, 1'b1);
                end
            end
            2: begin
                x   = a;
                y   = b;
                dx  = (d > a) ? d - a : a - d;
                dy  = -((e > b) ? e - b : b - e);
                sx  = (a < d) ? 1 : -1;
                sy  = (b < e) ? 1 : -1;
                err = dx + dy;
                for (int n = 0; n < 16; n++) begin
                    push(x, y, 1'b1);
                    if (x == d && y == e) break;
                    e2 = 2 * err;
                    if (e2 >= dy) begin err += dy; x += sx; end
                    if (e2 <= dx) begin err += dx; y += sy; end
                end
            end
            3: begin
                if (w != 0 && h != 0) begin
                    xe = (a + w - 1 > 7) ? 7 : a + w - 1;
                    ye = (b + h - 1 > 7) ? 7 : b + h - 1;
                    for (int yy = b; yy <= ye; yy++)
                        for (int xx = a; xx <= xe; xx++) push(xx, yy, 1'b1);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic scramble_inputs();
        bus.command     = 2'($urandom);
        bus.x1          = 3'($urandom);
        bus.y1          = 3'($urandom);
        bus.x2          = 3'($urandom);
        bus.y2          = 3'($urandom);
        bus.rect_width  = 3'($urandom);
        bus.rect_height = 3'($urandom);
    endtask

    task automatic drive(input logic [1:0] c, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                         input logic [2:0] e, input logic [2:0] w, input logic [2:0] h);
        bus.command       = c;
        bus.x1            = a;
        bus.y1            = b;
        bus.x2            = d;
        bus.y2            = e;
        bus.rect_width    = w;
        bus.rect_height   = h;
        bus.command_valid = 1'b1;
        build_expected(int'(c), int'(a), int'(b), int'(d), int'(e), int'(w), int'(h));
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_cmd(input string tag, input logic [1:0] c, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] d, input logic [2:0] e, input logic [2:0] w, input logic [2:0] h);
        drive(c, a, b, d, e, w, h);
        @(negedge clk);
        bus.command_valid = 1'b0;
        scramble_inputs();
        foreach (exp_q[i]) begin
            check_out($sformatf("%s.wr%0d", tag, i), 1'b1, exp_q[i].x, exp_q[i].y, exp_q[i].d, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
        if (exp_q.size() > 0) last_pix = exp_q[exp_q.size() - 1];
        check_out({tag, ".end"}, 1'b0, last_pix.x, last_pix.y, last_pix.d, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            check_out(tag, 1'b0, last_pix.x, last_pix.y, last_pix.d, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rc;
        logic [2:0] ra, rb;
        bit         exp_drop;

        rst_n             = 1'b0;
        bus.command_valid = 1'b0;
        scramble_inputs();
        last_pix          = '0;
        repeat (2) @(negedge clk);
        check_out("reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle("post_reset", 1);

        run_cmd("pixel35", 2'd1, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0);
        idle("pixel_gap", 1);
        run_cmd("clear", 2'd1, 3'd7, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
        run_cmd("line_fwd", 2'd2, 3'd0, 3'd0, 3'd7, 3'd3, 3'd0, 3'd0);
        run_cmd("line_rev", 2'd2, 3'd7, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0);
        run_cmd("line_zero", 2'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0);
        run_cmd("rect23", 2'd3, 3'd2, 3'd3, 3'd0, 3'd0, 3'd3, 3'd2);
        run_cmd("rect_clip", 2'd3, 3'd6, 3'd6, 3'd0, 3'd0, 3'd4, 3'd4);
        run_cmd("rect_w0", 2'd3, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd5);
        run_cmd("noop", 2'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0);
        idle("noop_gap", 2);

        // Two pulses land during a CLEAR.
        drive(2'd1, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        bus.command_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
`ifdef RASTER_SEQ_CMD_BUF_EN
            exp_drop = (i == 11);
`else
            exp_drop = (i == 6 || i == 11);
`endif
            check_out($sformatf("clr_busy.wr%0d", i), 1'b1, exp_q[i].x, exp_q[i].y, 1'b0, 1'b1, 1'b0, exp_drop);
            scramble_inputs();
            bus.command_valid = (i == 5 || i == 10);
            if (i == 5) begin
                bus.command = 2'd1; bus.x1 = 3'd2; bus.y1 = 3'd6;
            end else if (i == 10) begin
                bus.command = 2'd1; bus.x1 = 3'd1; bus.y1 = 3'd1;
            end
            @(negedge clk);
        end
        bus.command_valid = 1'b0;
        check_out("clr_busy.end", 1'b0, 3'd7, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
`ifdef RASTER_SEQ_CMD_BUF_EN
        check_out("buffered.wr", 1'b1, 3'd2, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_out("buffered.end", 1'b0, 3'd2, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        last_pix = pix_t'{x: 3'd2, y: 3'd6, d: 1'b1};
`else
        check_out("dropped.idle", 1'b0, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        last_pix = pix_t'{x: 3'd7, y: 3'd7, d: 1'b0};
`endif
        idle("buf_gap", 1);

        // Reset lands on the 10th CLEAR write.
        drive(2'd1, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        bus.command_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_out($sformatf("clr_rst.wr%0d", i), 1'b1, exp_q[i].x, exp_q[i].y, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i < 9) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1 check_out("rst_async", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_out("rst_hold", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n    = 1'b1;
        last_pix = '0;
        idle("rst_after", 2);
        run_cmd("pixel_after_rst", 2'd1, 3'd6, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0);

        for (int n = 0; n < 50; n++) begin
            rc = 2'($urandom_range(0, 3));
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            if (rc == 2'd1 && ra == 3'd7 && $urandom_range(0, 2) != 0) ra = 3'($urandom_range(0, 6));
            run_cmd($sformatf("rnd%0d", n), rc, ra, rb, 3'($urandom), 3'($urandom),
                    3'($urandom), 3'($urandom));
            if ($urandom_range(0, 3) == 0) idle("rnd_gap", 1 + $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
